// File: rtl/pc_gen_if.sv
// Fetch-stage control bundle between the pipeline and the PC generator.
// master drives the decode/exception controls, slave (pc_gen) returns the fetch state.
interface pc_gen_if;
  logic        F_stall;
  logic        D_fire;
  logic [31:0] D_pc;
  logic [2:0]  NPCOp;
  logic        b_result;
  logic [31:0] b_offset;
  logic [25:0] j_address;
  logic [31:0] reg_address;
  logic        req;
  logic        D_eret;
  logic [31:0] EPC;
  logic [31:0] F_pc;
  logic [31:0] npc;
  logic        F_adel;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_miss;

  modport master (
    output F_stall, D_fire, D_pc, NPCOp, b_result, b_offset, j_address,
           reg_address, req, D_eret, EPC,
    input  F_pc, npc, F_adel, ras_empty, ras_full, ras_miss
  );

  modport slave (
    input  F_stall, D_fire, D_pc, NPCOp, b_result, b_offset, j_address,
           reg_address, req, D_eret, EPC,
    output F_pc, npc, F_adel, ras_empty, ras_full, ras_miss
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised next-PC selection plus an advisory
// return-address stack that flags jr $ra predictions that would have missed.
module pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFF
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_J      = 3'b010,
    OP_JR     = 3'b011,
    OP_JAL    = 3'b100,
    OP_JR_RA  = 3'b101
  } npc_op_e;

  npc_op_e     op;
  logic [31:0] f_pc;
  logic [31:0] npc;
  logic [31:0] link_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;

  assign op        = npc_op_e'(bus.NPCOp);
  assign link_pc   = bus.D_pc + 32'd4;
  assign branch_pc = link_pc + (bus.b_offset << 2);
  assign jump_pc   = {link_pc[31:28], bus.j_address, 2'b00};

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    npc = f_pc + 32'd4;
    if (bus.req) begin
      npc = EXC_VEC;
    end else if (bus.D_eret) begin
      npc = bus.EPC;
    end else begin
      case (op)
        OP_BRANCH:        if (bus.b_result) npc = branch_pc;
        OP_J, OP_JAL:     npc = jump_pc;
        OP_JR, OP_JR_RA:  npc = bus.reg_address;
        default:          ;
      endcase
    end
  end

  // Exceptions and eret redirect fetch even while the front end is stalled.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc <= RESET_PC;
    end else if (!bus.F_stall || bus.req || bus.D_eret) begin
      f_pc <= npc;
    end
  end

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] count;
  logic          miss;
  logic          push;
  logic          pop;

  assign push    = bus.D_fire && !bus.req && (op == OP_JAL);
  assign pop     = bus.D_fire && !bus.req && (op == OP_JR_RA);
  assign top_idx = ptr - PW'(1);

  // NOTE: stack storage has no reset; entries above count are never read, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[ptr] <= bus.D_pc + 32'd8;
    end
  end

  // The write pointer wraps, so a push into a full stack replaces the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
      miss  <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (count != FULL_COUNT) begin
          count <= count + CW'(1);
        end
      end else if (pop) begin
        if (count == '0) begin
          miss <= 1'b1;
        end else begin
          ptr   <= top_idx;
          count <= count - CW'(1);
          miss  <= (ras_mem[top_idx] != bus.reg_address);
        end
      end
    end
  end

  assign bus.F_pc      = f_pc;
  assign bus.npc       = npc;
  assign bus.F_adel    = (f_pc[1:0] != 2'b00) || (f_pc < IMEM_BASE) || (f_pc > IMEM_LIMIT);
  assign bus.ras_empty = (count == '0);
  assign bus.ras_full  = (count == FULL_COUNT);
  assign bus.ras_miss  = miss;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random traffic,
// compared against a queue-based behavioural model of fetch PC and return stack.
module tb_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam int          DEPTH    = 4;

  logic clk;
  logic reset;
  pc_gen_if bus ();

  pc_gen #(
    .RESET_PC  (RESET_PC),
    .EXC_VEC   (EXC_VEC),
    .RAS_DEPTH (DEPTH),
    .IMEM_BASE (32'h0000_3000),
    .IMEM_LIMIT(32'h0000_6FFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] fpc_m;
  logic [31:0] ras_q[$];
  logic        miss_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc();
    logic [31:0] seq_pc = fpc_m + 32'd4;
    logic [31:0] after  = bus.D_pc + 32'd4;
    if (bus.req)    return EXC_VEC;
    if (bus.D_eret) return bus.EPC;
    case (bus.NPCOp)
      3'b001:         return bus.b_result ? after + bus.b_offset * 32'd4 : seq_pc;
      3'b010, 3'b100: return {after[31:28], bus.j_address, 2'b00};
      3'b011, 3'b101: return bus.reg_address;
      default:        return seq_pc;
    endcase
  endfunction

  function automatic logic model_adel();
    return (fpc_m % 4 != 0) || (fpc_m < 32'h3000) || (fpc_m > 32'h6FFF);
  endfunction

  task automatic model_reset();
    fpc_m  = RESET_PC;
    ras_q.delete();
    miss_m = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] nxt = model_npc();
    logic [31:0] top;
    miss_m = 1'b0;
    if (bus.D_fire && !bus.req) begin
      if (bus.NPCOp == 3'b100) begin
        ras_q.push_back(bus.D_pc + 32'd8);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end else if (bus.NPCOp == 3'b101) begin
        if (ras_q.size() == 0) begin
          miss_m = 1'b1;
        end else begin
          top    = ras_q.pop_back();
          miss_m = (top != bus.reg_address);
        end
      end
    end
    if (!bus.F_stall || bus.req || bus.D_eret) fpc_m = nxt;
  endtask

  task automatic set_idle();
    bus.F_stall     = 1'b0;
    bus.D_fire      = 1'b0;
    bus.D_pc        = 32'h0;
    bus.NPCOp       = 3'b000;
    bus.b_result    = 1'b0;
    bus.b_offset    = 32'h0;
    bus.j_address   = 26'h0;
    bus.reg_address = 32'h0;
    bus.req         = 1'b0;
    bus.D_eret      = 1'b0;
    bus.EPC         = 32'h0;
  endtask

  task automatic half_neg();
    @(negedge clk);
    check("npc", bus.npc, model_npc());
    check("adel_pre", {31'b0, bus.F_adel}, {31'b0, model_adel()});
  endtask

  task automatic half_pos();
    @(posedge clk);
    model_edge();
    #1;
    check("f_pc", bus.F_pc, fpc_m);
    check("ras_empty", {31'b0, bus.ras_empty}, {31'b0, ras_q.size() == 0});
    check("ras_full", {31'b0, bus.ras_full}, {31'b0, ras_q.size() == DEPTH});
    check("ras_miss", {31'b0, bus.ras_miss}, {31'b0, miss_m});
    check("adel_post", {31'b0, bus.F_adel}, {31'b0, model_adel()});
  endtask

  task automatic tick();
    half_neg();
    half_pos();
  endtask

  logic [31:0] jal_pc [5]  = '{32'h3000, 32'h3010, 32'h3020, 32'h3030, 32'h3040};
  logic [31:0] ret_pc [5]  = '{32'h3048, 32'h3038, 32'h3028, 32'h3018, 32'h3008};
  logic        ret_miss[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    set_idle();
    reset = 1'b0;
    model_reset();
    #12;
    check("rst_f_pc", bus.F_pc, RESET_PC);
    check("rst_empty", {31'b0, bus.ras_empty}, 32'd1);
    check("rst_full", {31'b0, bus.ras_full}, 32'd0);
    check("rst_miss", {31'b0, bus.ras_miss}, 32'd0);
    check("rst_adel", {31'b0, bus.F_adel}, 32'd0);

    @(posedge clk);
    #1 reset = 1'b1;
    check("rel_f_pc", bus.F_pc, 32'h3000);
    tick(); check("seq1", bus.F_pc, 32'h3004);
    tick(); check("seq2", bus.F_pc, 32'h3008);
    tick(); check("seq3", bus.F_pc, 32'h300C);
    tick(); check("seq4", bus.F_pc, 32'h3010);

    bus.F_stall = 1'b1; bus.req = 1'b1;
    tick(); check("stall_req", bus.F_pc, 32'h4180);
    bus.req = 1'b0;
    tick(); check("stall_hold", bus.F_pc, 32'h4180);

    bus.F_stall = 1'b0; bus.NPCOp = 3'b011; bus.reg_address = 32'h3024;
    tick(); check("jr_3024", bus.F_pc, 32'h3024);

    bus.F_stall = 1'b1; bus.NPCOp = 3'b001; bus.D_pc = 32'h3020;
    bus.b_result = 1'b1; bus.b_offset = 32'hFFFF_FFFE;
    half_neg(); check("br_taken", bus.npc, 32'h301C); half_pos();
    bus.b_result = 1'b0;
    half_neg(); check("br_not_taken", bus.npc, 32'h3028); half_pos();

    set_idle();
    bus.F_stall = 1'b1; bus.D_fire = 1'b1; bus.NPCOp = 3'b100;
    for (int i = 0; i < 5; i++) begin
      bus.D_pc = jal_pc[i];
      tick();
    end
    check("ras_full5", {31'b0, bus.ras_full}, 32'd1);
    bus.NPCOp = 3'b101;
    for (int i = 0; i < 5; i++) begin
      bus.reg_address = ret_pc[i];
      tick();
      check($sformatf("pop_miss%0d", i), {31'b0, bus.ras_miss}, {31'b0, ret_miss[i]});
    end
    check("ras_drained", {31'b0, bus.ras_empty}, 32'd1);
    set_idle(); bus.F_stall = 1'b1;
    tick(); check("miss_one_cycle", {31'b0, bus.ras_miss}, 32'd0);

    bus.D_eret = 1'b1; bus.EPC = 32'h3100; bus.req = 1'b1;
    half_neg(); check("eret_vs_req", bus.npc, 32'h4180); half_pos();
    bus.req = 1'b0;
    tick(); check("eret", bus.F_pc, 32'h3100);

    set_idle(); bus.NPCOp = 3'b011;
    bus.reg_address = 32'h3002; tick(); check("adel_misalign", {31'b0, bus.F_adel}, 32'd1);
    bus.reg_address = 32'h7000; tick(); check("adel_above", {31'b0, bus.F_adel}, 32'd1);
    bus.reg_address = 32'h6FFC; tick(); check("adel_last", {31'b0, bus.F_adel}, 32'd0);
    bus.reg_address = 32'hFFFF_FFFC; tick();
    bus.NPCOp = 3'b000; tick(); check("wrap", bus.F_pc, 32'h0);

    bus.D_fire = 1'b1; bus.NPCOp = 3'b100; bus.D_pc = 32'h3200;
    tick(); tick();
    set_idle();
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_pc", bus.F_pc, RESET_PC);
    check("async_rst_empty", {31'b0, bus.ras_empty}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(); check("post_rst_seq", bus.F_pc, 32'h3004);

    for (int i = 0; i < 400; i++) begin
      bus.F_stall   = ($urandom_range(0, 2) == 0);
      bus.D_fire    = $urandom_range(0, 1);
      bus.NPCOp     = 3'($urandom_range(0, 7));
      bus.D_pc      = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                  : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      bus.b_result  = $urandom_range(0, 1);
      bus.b_offset  = $urandom;
      bus.j_address = 26'($urandom);
      bus.reg_address = (ras_q.size() > 0 && $urandom_range(0, 2) != 0) ? ras_q[$] : $urandom;
      bus.req       = ($urandom_range(0, 7) == 0);
      bus.D_eret    = ($urandom_range(0, 7) == 0);
      bus.EPC       = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
